// File: rtl/car_pkg.sv
// Shared types and saturating arithmetic helpers for the parametrised car speed controller.
package car_pkg;

   typedef enum logic [1:0] {
      MODE_OFF    = 2'b00,
      MODE_STOP   = 2'b01,
      MODE_DRIVE  = 2'b10,
      MODE_CRUISE = 2'b11
   } car_mode_t;

   // Helpers work on a fixed wide operand; callers zero-extend and truncate back to SPEED_W.
   localparam int CALC_W = 16;

   function automatic logic [CALC_W-1:0] sat_add(input logic [CALC_W-1:0] speed,
                                                 input logic [CALC_W-1:0] inc,
                                                 input logic [CALC_W-1:0] max);
      logic [CALC_W-1:0] sum;
      sum = speed + inc;
      if (sum > max) begin
         return max;
      end else begin
         return sum;
      end
   endfunction

   function automatic logic [CALC_W-1:0] sat_sub(input logic [CALC_W-1:0] speed,
                                                 input logic [CALC_W-1:0] dec);
      if (speed > dec) begin
         return speed - dec;
      end else begin
         return {CALC_W{1'b0}};
      end
   endfunction

endpackage

// File: rtl/car_step_pacer.sv
// Divide-by-DIV step pacer: counts enabled cycles and ticks on the DIV-th one, then wraps.
module car_step_pacer #(
   parameter int DIV = 2
) (
   input  logic clock,
   input  logic reset_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt_r;

   assign tick = en && (cnt_r == CW'(DIV - 1));

   // Pacing counter; clear has priority over counting.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_r <= {CW{1'b0}};
      end else if (clr) begin
         cnt_r <= {CW{1'b0}};
      end else if (en) begin
         cnt_r <= tick ? {CW{1'b0}} : cnt_r + CW'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

endmodule

// File: rtl/car_speed_cntl_param.sv
// Car speed controller: OFF/STOP/DRIVE/CRUISE FSM with paced acceleration, braking and coasting.
module car_speed_cntl_param
   import car_pkg::*;
#(
   parameter int SPEED_W    = 3,
   parameter int MAX_SPEED  = 7,
   parameter int ACCEL_DIV  = 2,
   parameter int BRAKE_STEP = 2,
   parameter int COAST_DIV  = 4
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               keys,
   input  logic               brake,
   input  logic               accelerate,
   input  logic               cruise_set,
   input  logic               cruise_cancel,
   output logic [SPEED_W-1:0] speed,
   output logic [1:0]         mode,
   output logic               at_max,
   output logic [SPEED_W-1:0] cruise_target
);

   localparam bit COAST_ON  = (COAST_DIV > 0);
   localparam int COAST_EFF = COAST_ON ? COAST_DIV : 1;

   car_mode_t          mode_r, mode_next_s;
   logic [SPEED_W-1:0] speed_r, speed_next_s;
   logic [SPEED_W-1:0] target_r, target_next_s;
   logic               at_max_r;

   logic accel_en_s, accel_clr_s, accel_tick_s;
   logic coast_en_s, coast_clr_s, coast_tick_s;

   logic [SPEED_W-1:0] speed_inc_s, speed_dec1_s, speed_brk_s, target_inc_s;

   assign speed_inc_s  = SPEED_W'(sat_add(CALC_W'(speed_r), CALC_W'(1), CALC_W'(MAX_SPEED)));
   assign speed_dec1_s = SPEED_W'(sat_sub(CALC_W'(speed_r), CALC_W'(1)));
   assign speed_brk_s  = SPEED_W'(sat_sub(CALC_W'(speed_r), CALC_W'(BRAKE_STEP)));
   assign target_inc_s = SPEED_W'(sat_add(CALC_W'(target_r), CALC_W'(1), CALC_W'(MAX_SPEED)));

   car_step_pacer #(.DIV(ACCEL_DIV)) u_accel_pacer (
      .clock   (clock),
      .reset_n (reset_n),
      .en      (accel_en_s),
      .clr     (accel_clr_s),
      .tick    (accel_tick_s)
   );

   car_step_pacer #(.DIV(COAST_EFF)) u_coast_pacer (
      .clock   (clock),
      .reset_n (reset_n),
      .en      (coast_en_s),
      .clr     (coast_clr_s),
      .tick    (coast_tick_s)
   );

   // Next-state, speed datapath and pacer controls; priority keys > brake > cancel > set > accel > idle.
   always_comb begin
      mode_next_s   = mode_r;
      speed_next_s  = speed_r;
      target_next_s = target_r;
      accel_en_s    = 1'b0;
      accel_clr_s   = 1'b0;
      coast_en_s    = 1'b0;
      coast_clr_s   = 1'b0;

      if (!keys) begin
         mode_next_s   = MODE_OFF;
         speed_next_s  = {SPEED_W{1'b0}};
         target_next_s = {SPEED_W{1'b0}};
         accel_clr_s   = 1'b1;
         coast_clr_s   = 1'b1;
      end else begin
         case (mode_r)
            MODE_OFF: begin
               mode_next_s   = MODE_STOP;
               speed_next_s  = {SPEED_W{1'b0}};
               target_next_s = {SPEED_W{1'b0}};
               accel_clr_s   = 1'b1;
               coast_clr_s   = 1'b1;
            end
            MODE_STOP: begin
               coast_clr_s = 1'b1;
               if (accelerate && !brake) begin
                  accel_en_s = 1'b1;
                  if (accel_tick_s) begin
                     speed_next_s = speed_inc_s;
                     mode_next_s  = MODE_DRIVE;
                  end else begin
                     speed_next_s = speed_r;
                  end
               end else begin
                  accel_clr_s = 1'b1;
               end
            end
            MODE_DRIVE: begin
               if (brake) begin
                  accel_clr_s  = 1'b1;
                  coast_clr_s  = 1'b1;
                  speed_next_s = speed_brk_s;
                  mode_next_s  = (speed_brk_s == {SPEED_W{1'b0}}) ? MODE_STOP : MODE_DRIVE;
               end else if (cruise_set && !cruise_cancel && (speed_r != {SPEED_W{1'b0}})) begin
                  accel_clr_s   = 1'b1;
                  coast_clr_s   = 1'b1;
                  target_next_s = speed_r;
                  mode_next_s   = MODE_CRUISE;
               end else if (accelerate) begin
                  accel_en_s   = 1'b1;
                  coast_clr_s  = 1'b1;
                  speed_next_s = accel_tick_s ? speed_inc_s : speed_r;
               end else begin
                  // Idle: coast down only when coasting is configured.
                  accel_clr_s = 1'b1;
                  coast_en_s  = COAST_ON;
                  if (coast_tick_s) begin
                     speed_next_s = speed_dec1_s;
                     mode_next_s  = (speed_dec1_s == {SPEED_W{1'b0}}) ? MODE_STOP : MODE_DRIVE;
                  end else begin
                     speed_next_s = speed_r;
                  end
               end
            end
            MODE_CRUISE: begin
               if (brake) begin
                  accel_clr_s  = 1'b1;
                  coast_clr_s  = 1'b1;
                  speed_next_s = speed_brk_s;
                  mode_next_s  = (speed_brk_s == {SPEED_W{1'b0}}) ? MODE_STOP : MODE_DRIVE;
               end else if (cruise_cancel) begin
                  accel_clr_s = 1'b1;
                  coast_clr_s = 1'b1;
                  mode_next_s = MODE_DRIVE;
               end else if (cruise_set) begin
                  accel_clr_s   = 1'b1;
                  coast_clr_s   = 1'b1;
                  target_next_s = speed_r;
               end else if (accelerate) begin
                  accel_en_s  = 1'b1;
                  coast_clr_s = 1'b1;
                  if (accel_tick_s) begin
                     target_next_s = target_inc_s;
                     speed_next_s  = target_inc_s;
                  end else begin
                     speed_next_s = target_r;
                  end
               end else begin
                  accel_clr_s  = 1'b1;
                  coast_clr_s  = 1'b1;
                  speed_next_s = target_r;
               end
            end
            default: begin
               mode_next_s   = MODE_OFF;
               speed_next_s  = {SPEED_W{1'b0}};
               target_next_s = {SPEED_W{1'b0}};
               accel_clr_s   = 1'b1;
               coast_clr_s   = 1'b1;
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mode_r   <= MODE_OFF;
         speed_r  <= {SPEED_W{1'b0}};
         target_r <= {SPEED_W{1'b0}};
         at_max_r <= 1'b0;
      end else begin
         mode_r   <= mode_next_s;
         speed_r  <= speed_next_s;
         target_r <= target_next_s;
         at_max_r <= (speed_next_s == SPEED_W'(MAX_SPEED));
      end
   end

   assign speed         = speed_r;
   assign mode          = mode_r;
   assign at_max        = at_max_r;
   assign cruise_target = target_r;

endmodule

// File: tb/tb_car_speed_cntl_param.sv
// Directed table-driven bench for car_speed_cntl_param (defaults, plus a COAST_DIV=0 instance).
module tb_car_speed_cntl_param;

   localparam logic [1:0] M_OFF = 2'b00;
   localparam logic [1:0] M_STP = 2'b01;
   localparam logic [1:0] M_DRV = 2'b10;
   localparam logic [1:0] M_CRU = 2'b11;

   logic       clock;
   logic       reset_n;
   logic       keys, brake, accelerate, cruise_set, cruise_cancel;
   logic [2:0] speed, cruise_target, nc_speed, nc_target;
   logic [1:0] mode, nc_mode;
   logic       at_max, nc_at_max;

   int tests_run = 0;
   int tests_failed = 0;

   typedef struct {
      logic       k, b, a, cs, cc;
      logic [2:0] sp;
      logic [1:0] md;
      logic [2:0] tg;
      bit         chk_nc;
      logic [2:0] nc_sp;
   } vec_t;

   vec_t vecs[$];

   car_speed_cntl_param dut (
      .clock(clock), .reset_n(reset_n), .keys(keys), .brake(brake),
      .accelerate(accelerate), .cruise_set(cruise_set), .cruise_cancel(cruise_cancel),
      .speed(speed), .mode(mode), .at_max(at_max), .cruise_target(cruise_target)
   );

   car_speed_cntl_param #(.COAST_DIV(0)) dut_nc (
      .clock(clock), .reset_n(reset_n), .keys(keys), .brake(brake),
      .accelerate(accelerate), .cruise_set(cruise_set), .cruise_cancel(cruise_cancel),
      .speed(nc_speed), .mode(nc_mode), .at_max(nc_at_max), .cruise_target(nc_target)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input int act, input int exp);
      tests_run++;
      if (act != exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic add(input logic k, b, a, cs, cc, input int sp, input logic [1:0] md,
                      input int tg, input bit cn, input int ncs);
      vec_t v;
      v.k = k; v.b = b; v.a = a; v.cs = cs; v.cc = cc;
      v.sp = 3'(sp); v.md = md; v.tg = 3'(tg); v.chk_nc = cn; v.nc_sp = 3'(ncs);
      vecs.push_back(v);
   endtask

   task automatic drive(input logic k, b, a, cs, cc);
      keys = k; brake = b; accelerate = a; cruise_set = cs; cruise_cancel = cc;
   endtask

   initial begin
      int s;
      reset_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Keys on, idle: OFF -> STOP
      for (int i = 0; i < 3; i++) add(1,0,0,0,0, 0, M_STP, 0, 0, 0);
      // Ramp: one step every 2 cycles, saturate at 7
      for (int i = 1; i <= 16; i++) begin
         s = (i / 2 > 7) ? 7 : i / 2;
         add(1,0,1,0,0, s, (s > 0) ? M_DRV : M_STP, 0, 0, 0);
      end
      // Brake from 7 in steps of 2, STOP exactly at 0
      add(1,1,0,0,0, 5, M_DRV, 0, 0, 0);
      add(1,1,0,0,0, 3, M_DRV, 0, 0, 0);
      add(1,1,0,0,0, 1, M_DRV, 0, 0, 0);
      add(1,1,0,0,0, 0, M_STP, 0, 0, 0);
      // Up to 4, then brake+accelerate together
      for (int i = 1; i <= 8; i++) add(1,0,1,0,0, i / 2, (i >= 2) ? M_DRV : M_STP, 0, 0, 0);
      add(1,1,1,0,0, 2, M_DRV, 0, 0, 0);
      add(1,1,0,0,0, 0, M_STP, 0, 0, 0);
      // Up to 5 on both instances, then idle: coast vs. hold
      for (int i = 1; i <= 10; i++) add(1,0,1,0,0, i / 2, (i >= 2) ? M_DRV : M_STP, 0, 1, i / 2);
      for (int i = 1; i <= 8; i++) add(1,0,0,0,0, (i < 4) ? 5 : (i < 8) ? 4 : 3, M_DRV, 0, 1, 5);
      // Cruise at 3
      add(1,0,0,1,0, 3, M_CRU, 3, 0, 0);
      for (int i = 0; i < 10; i++) add(1,0,0,0,0, 3, M_CRU, 3, 0, 0);
      add(1,0,1,0,0, 3, M_CRU, 3, 0, 0);
      add(1,0,1,0,0, 4, M_CRU, 4, 0, 0);
      add(1,0,1,0,0, 4, M_CRU, 4, 0, 0);
      add(1,0,1,0,0, 5, M_CRU, 5, 0, 0);
      add(1,0,0,0,1, 5, M_DRV, 5, 0, 0);
      add(1,0,0,1,0, 5, M_CRU, 5, 0, 0);
      add(1,1,0,0,0, 3, M_DRV, 5, 0, 0);
      // Up to 4, cruise, keys off, then cruise_set in STOP
      add(1,0,1,0,0, 3, M_DRV, 5, 0, 0);
      add(1,0,1,0,0, 4, M_DRV, 5, 0, 0);
      add(1,0,0,1,0, 4, M_CRU, 4, 0, 0);
      add(0,0,0,0,0, 0, M_OFF, 0, 0, 0);
      add(1,0,0,0,0, 0, M_STP, 0, 0, 0);
      add(1,0,0,1,0, 0, M_STP, 0, 0, 0);

      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      check("reset_speed",  int'(speed), 0);
      check("reset_mode",   int'(mode), int'(M_OFF));
      check("reset_at_max", int'(at_max), 0);
      check("reset_target", int'(cruise_target), 0);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clock);
         drive(vecs[i].k, vecs[i].b, vecs[i].a, vecs[i].cs, vecs[i].cc);
         @(posedge clock);
         #1;
         check($sformatf("row%0d_speed", i),  int'(speed), int'(vecs[i].sp));
         check($sformatf("row%0d_mode", i),   int'(mode), int'(vecs[i].md));
         check($sformatf("row%0d_at_max", i), int'(at_max), (vecs[i].sp == 3'd7) ? 1 : 0);
         check($sformatf("row%0d_target", i), int'(cruise_target), int'(vecs[i].tg));
         if (vecs[i].chk_nc) begin
            check($sformatf("row%0d_nocoast_speed", i), int'(nc_speed), int'(vecs[i].nc_sp));
         end else begin
            tests_run = tests_run;
         end
      end

      // Mid-ramp asynchronous reset: outputs clear before the next edge
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      @(posedge clock);
      #1;
      check("ramp_speed_before_reset", int'(speed), 3);
      #1;
      reset_n = 1'b0;
      #1;
      check("async_reset_speed",  int'(speed), 0);
      check("async_reset_mode",   int'(mode), int'(M_OFF));
      check("async_reset_target", int'(cruise_target), 0);
      check("async_reset_at_max", int'(at_max), 0);
      @(negedge clock);
      reset_n = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clock);
      #1;
      check("post_reset_mode", int'(mode), int'(M_STP));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
